// File: rtl/bus_pkg.sv
// Shared types and helpers for the system-bus arbiter.
// Latency: none (declarations and combinational helpers only).
// Backpressure: not applicable.
// Contents: arbiter state enum, width limits, select-width helper, rr_pick().
package bus_pkg;

  // Upper bound on masters; the picker works on a vector of this width.
  localparam int MAX_MASTERS = 8;
  localparam int MAX_SEL_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Width of a master index; the per-instance MSEL_W is derived from this.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Winner = first set bit of req searching upward, with wrap, from last+1.
  // Only the low n bits of req take part. Returns 0 when nothing is set.
  function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                 input int last, input int n);
    int                   pick;
    logic                 found;
    logic [MAX_SEL_W-1:0] cand;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      cand = MAX_SEL_W'((last + k) % n);
      if ((k <= n) && !found && req[cand]) begin
        found = 1'b1;
        pick  = int'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Masked request picker: round-robin after i_last, or fixed lowest-index-wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on o_vld/o_idx.
// Ports: i_req/i_mask (N bits), i_last (previous owner) -> o_vld (any eligible),
//        o_idx (winning index).
module rr_priority_enc
  import bus_pkg::*;
#(
  parameter int N       = 2,
  parameter bit RR_MODE = 1'b1,
  parameter int SW      = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [SW-1:0] i_last,
  output logic          o_vld,
  output logic [SW-1:0] o_idx
);

  logic [N-1:0]           w_elig;
  logic [MAX_MASTERS-1:0] w_elig_ext;
  int                     w_start;

  assign w_elig     = i_req & ~i_mask;
  assign w_elig_ext = MAX_MASTERS'(w_elig);

  // Fixed priority is the same search started just after the top index,
  // so it always begins at master 0.
  assign w_start = RR_MODE ? int'(i_last) : (N - 1);

  assign o_vld = |w_elig;
  assign o_idx = SW'(rr_pick(w_elig_ext, w_start, N));

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: one-hot grant to one of NUM_MASTERS, turnaround cycle, grant watchdog.
// Latency: request sampled in IDLE -> registered grant one cycle later; one idle cycle between owners.
// Backpressure: owner keeps i_breq high for its whole transaction; others simply wait, no pre-emption.
// Ports: i_clk, i_rstn (sync, active low), i_breq -> o_bgrant, o_msel, o_bus_busy,
//        o_timeout_err (1-cycle pulse), o_err_master (held until next timeout).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter bit RR_MODE        = 1'b1,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int MSEL_W        = sel_width(NUM_MASTERS)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [NUM_MASTERS-1:0] i_breq,
  output logic [NUM_MASTERS-1:0] o_bgrant,
  output logic [MSEL_W-1:0]      o_msel,
  output logic                   o_bus_busy,
  output logic                   o_timeout_err,
  output logic [MSEL_W-1:0]      o_err_master
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [MSEL_W-1:0] LAST_RST = MSEL_W'(NUM_MASTERS - 1);

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_bgrant;
  logic                   r_bus_busy;
  logic [MSEL_W-1:0]      r_msel;
  logic [MSEL_W-1:0]      r_last_owner;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_MASTERS-1:0] r_mask;
  logic                   r_timeout_err;
  logic [MSEL_W-1:0]      r_err_master;

  logic                   w_win_vld;
  logic [MSEL_W-1:0]      w_win_idx;
  logic [NUM_MASTERS-1:0] w_win_onehot;
  logic                   w_owner_req;
  logic                   w_expired;

  rr_priority_enc #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE),
    .SW      (MSEL_W)
  ) u_pick (
    .i_req  (i_breq),
    .i_mask (r_mask),
    .i_last (r_last_owner),
    .o_vld  (w_win_vld),
    .o_idx  (w_win_idx)
  );

  assign w_win_onehot = NUM_MASTERS'(1) << w_win_idx;

  // While OWNED, r_msel is the owner.
  assign w_owner_req = i_breq[r_msel];
  assign w_expired   = WDOG_EN && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state       <= ST_IDLE;
      r_bgrant      <= '0;
      r_bus_busy    <= 1'b0;
      r_msel        <= '0;
      r_last_owner  <= LAST_RST;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_timeout_err <= 1'b0;
      r_err_master  <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      // A mask bit only survives while its master keeps requesting.
      r_mask        <= r_mask & i_breq;

      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_bgrant     <= w_win_onehot;
            r_bus_busy   <= 1'b1;
            r_msel       <= w_win_idx;
            r_last_owner <= w_win_idx;
            r_cnt        <= '0;
            r_state      <= ST_OWNED;
          end
        end

        ST_OWNED: begin
          // A voluntary release takes precedence over an expiry on the same cycle.
          if (!w_owner_req) begin
            r_bgrant   <= '0;
            r_bus_busy <= 1'b0;
            r_state    <= ST_TURN;
          end else if (w_expired) begin
            r_bgrant      <= '0;
            r_bus_busy    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_err_master  <= r_msel;
            // r_bgrant is the owner's one-hot; lock it out until it drops breq.
            r_mask        <= (r_mask & i_breq) | r_bgrant;
            r_state       <= ST_TURN;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_TURN: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_bgrant      = r_bgrant;
  assign o_msel        = r_msel;
  assign o_bus_busy    = r_bus_busy;
  assign o_timeout_err = r_timeout_err;
  assign o_err_master  = r_err_master;

  a_grant_onehot : assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(r_bgrant));
  a_busy_match   : assert property (@(posedge i_clk) disable iff (!i_rstn) r_bus_busy == (|r_bgrant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, hand-written corner sequences and random traffic
// against a behavioural model, on three configurations (RR/T=16, fixed/T=16, 3-master RR/no watchdog).
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [2:0] breq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // DUT A: 2 masters, round-robin, watchdog 16
  logic [1:0] rr_gnt;
  logic [0:0] rr_msel, rr_errm;
  logic       rr_busy, rr_terr;
  // DUT B: 2 masters, fixed priority, watchdog 16
  logic [1:0] fp_gnt;
  logic [0:0] fp_msel, fp_errm;
  logic       fp_busy, fp_terr;
  // DUT C: 3 masters, round-robin, watchdog disabled
  logic [2:0] r3_gnt;
  logic [1:0] r3_msel, r3_errm;
  logic       r3_busy, r3_terr;

  bus_arbiter #(.NUM_MASTERS(2), .RR_MODE(1'b1), .TIMEOUT_CYCLES(16)) u_rr (
    .i_clk(clk), .i_rstn(rstn), .i_breq(breq[1:0]),
    .o_bgrant(rr_gnt), .o_msel(rr_msel), .o_bus_busy(rr_busy),
    .o_timeout_err(rr_terr), .o_err_master(rr_errm));

  bus_arbiter #(.NUM_MASTERS(2), .RR_MODE(1'b0), .TIMEOUT_CYCLES(16)) u_fp (
    .i_clk(clk), .i_rstn(rstn), .i_breq(breq[1:0]),
    .o_bgrant(fp_gnt), .o_msel(fp_msel), .o_bus_busy(fp_busy),
    .o_timeout_err(fp_terr), .o_err_master(fp_errm));

  bus_arbiter #(.NUM_MASTERS(3), .RR_MODE(1'b1), .TIMEOUT_CYCLES(0)) u_r3 (
    .i_clk(clk), .i_rstn(rstn), .i_breq(breq),
    .o_bgrant(r3_gnt), .o_msel(r3_msel), .o_bus_busy(r3_busy),
    .o_timeout_err(r3_terr), .o_err_master(r3_errm));

  // ---------------- behavioural reference ----------------
  // owner = -1 when nobody holds the bus; gap marks the mandatory idle cycle
  // after a release; held = cycles the current grant has been visible.
  typedef struct {
    int       owner;
    bit       gap;
    int       last;
    int       held;
    bit [7:0] mask;
    int       msel;
    int       errm;
    bit       terr;
  } mdl_t;

  mdl_t m_rr, m_fp, m_r3;

  function automatic bit bitof(input bit [7:0] v, input int i);
    return v[i[2:0]];
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit rst_n, input bit [7:0] req,
                                    input int n, input bit rr, input int tmo);
    mdl_t r;
    int   start;
    int   w;
    r      = m;
    r.terr = 1'b0;
    if (!rst_n) begin
      r.owner = -1; r.gap = 1'b0; r.last = n - 1; r.held = 0;
      r.mask = '0; r.msel = 0; r.errm = 0;
      return r;
    end
    for (int i = 0; i < n; i++)
      if (!bitof(req, i)) r.mask = r.mask & ~(8'd1 << i);
    if (m.owner >= 0) begin
      if (!bitof(req, m.owner)) begin
        r.owner = -1; r.gap = 1'b1;
      end else if (tmo != 0 && m.held >= tmo) begin
        r.owner = -1; r.gap = 1'b1; r.terr = 1'b1; r.errm = m.owner;
        r.mask  = r.mask | (8'd1 << m.owner);
      end else begin
        r.held = m.held + 1;
      end
    end else if (m.gap) begin
      r.gap = 1'b0;
    end else begin
      start = rr ? m.last + 1 : 0;
      for (int k = 0; k < n; k++) begin
        w = (start + k) % n;
        if (r.owner < 0 && bitof(req, w) && !bitof(m.mask, w)) r.owner = w;
      end
      if (r.owner >= 0) begin
        r.last = r.owner; r.msel = r.owner; r.held = 1;
      end
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input int gnt, input int busy,
                     input int msel, input int terr, input int errm);
    int eg;
    eg = (m.owner >= 0) ? (1 << m.owner) : 0;
    chk({tag, ".bgrant"}, gnt, eg);
    chk({tag, ".bus_busy"}, busy, (eg != 0) ? 1 : 0);
    chk({tag, ".msel"}, msel, m.msel);
    chk({tag, ".timeout_err"}, terr, int'(m.terr));
    chk({tag, ".err_master"}, errm, m.errm);
  endtask

  // Drive inputs away from the edge, let the DUTs and models take the edge, compare on negedge.
  task automatic step(input logic r, input logic [2:0] q);
    rstn = r;
    breq = q;
    @(posedge clk);
    m_rr = mdl_step(m_rr, r, 8'(q), 2, 1'b1, 16);
    m_fp = mdl_step(m_fp, r, 8'(q), 2, 1'b0, 16);
    m_r3 = mdl_step(m_r3, r, 8'(q), 3, 1'b1, 0);
    @(negedge clk);
    cyc++;
    cmp("rr", m_rr, int'(rr_gnt), int'(rr_busy), int'(rr_msel), int'(rr_terr), int'(rr_errm));
    cmp("fp", m_fp, int'(fp_gnt), int'(fp_busy), int'(fp_msel), int'(fp_terr), int'(fp_errm));
    cmp("r3", m_r3, int'(r3_gnt), int'(r3_busy), int'(r3_msel), int'(r3_terr), int'(r3_errm));
  endtask

  // ---------------- directed vectors for the round-robin instance ----------------
  typedef struct {
    logic       rstn;
    logic [1:0] breq;
    logic [1:0] gnt;
    logic       msel;
  } vec_t;

  vec_t       tbl [22];
  logic [2:0] q;
  logic       r;

  initial begin
    rstn = 1'b0;
    breq = '0;
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b0};  // reset
    tbl[1]  = '{1'b0, 2'b01, 2'b00, 1'b0};  // request ignored under reset
    tbl[2]  = '{1'b1, 2'b01, 2'b01, 1'b0};  // grant one cycle after request
    tbl[3]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[4]  = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 2'b00, 1'b0};  // release
    tbl[6]  = '{1'b1, 2'b10, 2'b00, 1'b0};  // turnaround, new request waits
    tbl[7]  = '{1'b1, 2'b10, 2'b10, 1'b1};
    tbl[8]  = '{1'b1, 2'b11, 2'b10, 1'b1};  // no pre-emption
    tbl[9]  = '{1'b1, 2'b01, 2'b00, 1'b1};  // msel holds last owner
    tbl[10] = '{1'b1, 2'b01, 2'b00, 1'b1};
    tbl[11] = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 2'b01, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 2'b00, 1'b0};
    tbl[14] = '{1'b1, 2'b11, 2'b00, 1'b0};
    tbl[15] = '{1'b1, 2'b11, 2'b10, 1'b1};  // both request: rotates to 1
    tbl[16] = '{1'b1, 2'b01, 2'b00, 1'b1};
    tbl[17] = '{1'b1, 2'b01, 2'b00, 1'b1};
    tbl[18] = '{1'b1, 2'b01, 2'b01, 1'b0};
    tbl[19] = '{1'b1, 2'b00, 2'b00, 1'b0};
    tbl[20] = '{1'b1, 2'b00, 2'b00, 1'b0};
    tbl[21] = '{1'b1, 2'b00, 2'b00, 1'b0};

    @(negedge clk);

    for (int k = 0; k < 22; k++) begin
      step(tbl[k].rstn, {1'b0, tbl[k].breq});
      chk("tbl.bgrant", int'(rr_gnt), int'(tbl[k].gnt));
      chk("tbl.bus_busy", int'(rr_busy), int'(|tbl[k].gnt));
      chk("tbl.msel", int'(rr_msel), int'(tbl[k].msel));
      chk("tbl.timeout_err", int'(rr_terr), 0);
    end

    // Fixed priority: master 0 keeps winning while it re-requests within the turnaround.
    step(1'b0, 3'b000);
    step(1'b1, 3'b011);
    chk("fp.first", int'(fp_gnt), 1);
    chk("rr.first", int'(rr_gnt), 1);
    for (int k = 0; k < 4; k++) step(1'b1, 3'b011);
    step(1'b1, 3'b010);
    chk("fp.release", int'(fp_gnt), 0);
    step(1'b1, 3'b011);
    chk("fp.turn", int'(fp_gnt), 0);
    step(1'b1, 3'b011);
    chk("fp.regrant0", int'(fp_gnt), 1);
    chk("rr.rotate1", int'(rr_gnt), 2);
    for (int k = 0; k < 4; k++) step(1'b1, 3'b011);
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    chk("fp.grant1", int'(fp_gnt), 2);
    chk("fp.msel1", int'(fp_msel), 1);

    // Watchdog: master 1 holds past 16 cycles while master 0 waits.
    step(1'b0, 3'b000);
    step(1'b1, 3'b010);
    chk("wd.grant1", int'(rr_gnt), 2);
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 3'b011);
      chk("wd.hold", int'(rr_gnt), 2);
      chk("wd.no_err", int'(rr_terr), 0);
    end
    step(1'b1, 3'b011);
    chk("wd.revoke", int'(rr_gnt), 0);
    chk("wd.pulse", int'(rr_terr), 1);
    chk("wd.err_master", int'(rr_errm), 1);
    step(1'b1, 3'b011);
    chk("wd.pulse_end", int'(rr_terr), 0);
    chk("wd.turn", int'(rr_gnt), 0);
    step(1'b1, 3'b011);
    chk("wd.next0", int'(rr_gnt), 1);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b011);
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    chk("wd.masked_a", int'(rr_gnt), 0);
    step(1'b1, 3'b010);
    chk("wd.masked_b", int'(rr_gnt), 0);
    step(1'b1, 3'b000);
    step(1'b1, 3'b010);
    chk("wd.regrant1", int'(rr_gnt), 2);
    chk("wd.err_held", int'(rr_errm), 1);

    // Race: owner releases on the very cycle the watchdog would fire.
    step(1'b0, 3'b000);
    step(1'b1, 3'b001);
    chk("race.grant", int'(rr_gnt), 1);
    for (int k = 1; k < 16; k++) step(1'b1, 3'b001);
    chk("race.still_owned", int'(rr_gnt), 1);
    step(1'b1, 3'b000);
    chk("race.release", int'(rr_gnt), 0);
    chk("race.no_pulse", int'(rr_terr), 0);
    step(1'b1, 3'b001);
    step(1'b1, 3'b001);
    chk("race.no_mask", int'(rr_gnt), 1);
    chk("race.err_master", int'(rr_errm), 0);

    // Reset while master 1 owns the bus.
    step(1'b0, 3'b000);
    step(1'b1, 3'b010);
    step(1'b1, 3'b010);
    chk("rst.owned1", int'(rr_gnt), 2);
    step(1'b0, 3'b011);
    chk("rst.drop", int'(rr_gnt), 0);
    chk("rst.msel", int'(rr_msel), 0);
    chk("rst.busy", int'(rr_busy), 0);
    step(1'b1, 3'b011);
    chk("rst.first0", int'(rr_gnt), 1);

    // Random traffic: requests toggle rarely so holds often outlast the watchdog.
    q = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(15) == 0) q[i] = ~q[i];
      r = ($urandom_range(399) != 0);
      step(r, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Grants ownership of the shared system bus to one of NUM_MASTERS bus-master ports; drives the master-side mux select and per-master grant lines.
- Sits between the master ports (the two demo-driven masters in the top level) and the shared address/data path to the slaves.
- Supports fixed or round-robin priority, an idle turnaround cycle between owners, and a watchdog that revokes a grant held too long.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT_CYCLES, 256, max cycles a grant may be held; 0 disables the watchdog

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset, sampled on rising clk
- breq  input  NUM_MASTERS  per-master request; the owner holds it high for its whole transaction
- bgrant  output  NUM_MASTERS  registered one-hot grant, or all zero
- msel  output  $clog2(NUM_MASTERS)  index of the current or last owner, for the bus mux
- bus_busy  output  1  high while any grant is asserted
- timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog
- err_master  output  $clog2(NUM_MASTERS)  index of the master that timed out; held until the next timeout

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rstn.
- Reset (rstn=0 at posedge):
  - state=IDLE; bgrant=0, bus_busy=0, timeout_err=0, msel=0, err_master=0.
  - last_owner=NUM_MASTERS-1, so master 0 wins first in RR mode; timeout counter=0; mask=0.
  - Reset mid-transaction drops the grant on that same edge.
- States: IDLE, OWNED, TURN.
- IDLE:
  - Eligible requests = breq & ~mask.
  - If any are eligible, pick a winner:
    - RR_MODE=1: first eligible index searching upward, with wrap, from last_owner+1.
    - RR_MODE=0: lowest eligible index.
  - On the next edge: bgrant=onehot(winner), msel=winner, last_owner=winner, counter=0, go to OWNED.
  - Latency: a request sampled in IDLE gives a grant 1 cycle later.
- OWNED:
  - If breq[owner]=0: bgrant=0, go to TURN.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: bgrant=0, timeout_err=1 for one cycle, err_master=owner, mask[owner]=1, go to TURN.
  - Else counter increments.
  - Other requests are ignored; there is no pre-emption.
- TURN:
  - One idle cycle with bgrant=0, then IDLE.
  - Back-to-back owners therefore always see one bus-idle cycle between grants.
- Mask:
  - mask[i] clears on any cycle where breq[i]=0.
  - A timed-out master cannot be regranted until it drops its request.
  - Its peers are unaffected.
- Simultaneous events:
  - If the owner drops breq in the same cycle the counter expires, the drop wins: no timeout_err, no mask.
  - A request that rises in TURN is considered in the following IDLE cycle.
- bus_busy = |bgrant, and is registered with it.
- msel holds the last owner while idle, so the mux stays stable.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- A non-onehot bgrant is illegal; the RTL carries an assertion for it.

Decomposition:
- Shared package bus_pkg:
  - arbiter state enum (IDLE, OWNED, TURN)
  - localparam MSEL_W = $clog2(NUM_MASTERS)
  - function rr_pick(req, last) returning the winner index
- Sub-module rr_priority_enc: combinational masked round-robin/fixed-priority picker, instantiated once.
- FSM, counter and mask live in bus_arbiter.

Test Plan:
- Single master, RR=1, TIMEOUT=256: breq=01 at cycle 3, held 10 cycles -> bgrant=01 at cycle 4; bgrant=00 one cycle after breq drops; one TURN cycle; bus_busy follows bgrant.
- Both masters, RR=1: breq=11 continuously, each holding 5 cycles, then dropping for 1 cycle before re-requesting -> grant order 0,1,0,1; a one-cycle bgrant=00 gap between every pair.
- Fixed priority, RR=0: breq=11 throughout, owners drop after 5 cycles -> master 0 is regranted every time; master 1 is granted only after master 0 deasserts for an IDLE sample.
- Watchdog, TIMEOUT=16: master 1 holds breq for 40 cycles while master 0 requests -> grant 1 revoked 16 cycles after grant; timeout_err pulses once; err_master=1; next grant goes to 0. Master 1 is not regranted until its breq drops and re-rises.
- Race: owner drops breq on the exact expiry cycle (TIMEOUT=16) -> timeout_err stays 0, mask stays 0, normal TURN.
- Reset mid-operation: rstn=0 for 1 cycle while master 1 owns the bus -> bgrant=00, msel=0 on that edge. After release with breq=11 and RR=1, master 0 is granted first.
